// File: rtl/fp16_pkg.sv
// Shared binary16 helpers for the numeric blocks: field widths, key encodings,
// an integer-to-binary16 floor encoder and NaN/Inf field tests.
package fp16_pkg;

  localparam int FP16_EXP_W    = 5;
  localparam int FP16_MAN_W    = 10;
  localparam int FP16_EXP_BIAS = 15;

  localparam logic [15:0] FP16_MAX_FINITE = 16'h7BFF;
  localparam logic [15:0] FP16_POS_INF    = 16'h7C00;

  // Largest finite binary16 value <= value, as a bit pattern. Low bits beyond the
  // 10-bit mantissa are truncated, which is exactly a floor for positive integers.
  function automatic logic [15:0] int_to_fp16_floor(input int unsigned value);
    logic [15:0] enc;
    logic [31:0] v;
    logic [31:0] man_full;
    int          msb;
    enc      = '0;
    v        = value;
    man_full = '0;
    msb      = 0;
    if (v == 32'd0) begin
      enc = '0;
    end else if (v >= 32'd65504) begin
      enc = FP16_MAX_FINITE;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) msb = i;
      end
      if (msb >= FP16_MAN_W) man_full = v >> (msb - FP16_MAN_W);
      else                   man_full = v << (FP16_MAN_W - msb);
      enc = {1'b0, 5'(msb + FP16_EXP_BIAS), man_full[FP16_MAN_W-1:0]};
    end
    return enc;
  endfunction

  // Field tests take the 15-bit magnitude; the sign never matters for them.
  function automatic logic is_nan(input logic [14:0] mag);
    return (&mag[14:10]) && (|mag[9:0]);
  endfunction

  function automatic logic is_inf(input logic [14:0] mag);
    return (&mag[14:10]) && !(|mag[9:0]);
  endfunction

endpackage

// File: rtl/fp16_comparator.sv
// Outlier flag for one binary16 element: result = |data_in| > THRES.
// Positive binary16 patterns order the same as their values, so the test is a
// single unsigned compare of the magnitude bits against the floor encoding of THRES.
module fp16_comparator
  import fp16_pkg::*;
#(
  parameter int          IN_WIDTH        = 16,
  parameter int          IN_FRAC_WIDTH   = 0,
  parameter int unsigned THRES           = 127,
  parameter int          REGISTER_OUTPUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] data_in,
  output logic                result
);

  // Accepted for interface uniformity with the other numeric blocks; no effect here.
  localparam int unused_frac_width = IN_FRAC_WIDTH;

  if (IN_WIDTH != 16) begin : g_bad_width
    $fatal(1, "fp16_comparator: IN_WIDTH must be 16");
  end

  if (THRES < 1 || THRES > 65535) begin : g_bad_thres
    $fatal(1, "fp16_comparator: THRES must be in 1..65535");
  end

  // x > THRES iff x > floor_fp16(THRES), so non-representable thresholds stay exact.
  localparam logic [15:0] T_ENC = int_to_fp16_floor(THRES);

  logic [14:0] mag;
  logic        raw;
  logic        unused_sign;

  assign mag         = data_in[14:0];
  assign unused_sign = data_in[IN_WIDTH-1];

  // NaN never flags; Inf always does (it also sorts above every finite threshold).
  assign raw = !is_nan(mag) && (is_inf(mag) || (mag > T_ENC[14:0]));

  if (REGISTER_OUTPUT != 0) begin : g_reg
    logic result_q;

    // One-cycle output flop, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) result_q <= 1'b0;
      else      result_q <= raw;
    end

    assign result = result_q;
  end else begin : g_comb
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign result         = raw;
  end

endmodule

// File: tb/tb_fp16_comparator.sv
// Self-checking bench for fp16_comparator: directed cases, exhaustive sweeps and
// random streams against a real-valued reference model.
module tb_fp16_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_r;
  logic [15:0] data_c;
  logic [15:0] data_r;

  logic res_127, res_2049, res_65535, res_1, res_1000, res_65504, res_reg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp16_comparator #(.IN_WIDTH(16), .IN_FRAC_WIDTH(0), .THRES(127),   .REGISTER_OUTPUT(0))
    u_t127   (.clk(clk), .rst(rst_n), .data_in(data_c), .result(res_127));
  fp16_comparator #(.IN_WIDTH(16), .IN_FRAC_WIDTH(0), .THRES(2049),  .REGISTER_OUTPUT(0))
    u_t2049  (.clk(clk), .rst(rst_n), .data_in(data_c), .result(res_2049));
  fp16_comparator #(.IN_WIDTH(16), .IN_FRAC_WIDTH(0), .THRES(65535), .REGISTER_OUTPUT(0))
    u_t65535 (.clk(clk), .rst(rst_n), .data_in(data_c), .result(res_65535));
  fp16_comparator #(.IN_WIDTH(16), .IN_FRAC_WIDTH(0), .THRES(1),     .REGISTER_OUTPUT(0))
    u_t1     (.clk(clk), .rst(rst_n), .data_in(data_c), .result(res_1));
  fp16_comparator #(.IN_WIDTH(16), .IN_FRAC_WIDTH(0), .THRES(1000),  .REGISTER_OUTPUT(0))
    u_t1000  (.clk(clk), .rst(rst_n), .data_in(data_c), .result(res_1000));
  fp16_comparator #(.IN_WIDTH(16), .IN_FRAC_WIDTH(0), .THRES(65504), .REGISTER_OUTPUT(0))
    u_t65504 (.clk(clk), .rst(rst_n), .data_in(data_c), .result(res_65504));
  fp16_comparator #(.IN_WIDTH(16), .IN_FRAC_WIDTH(0), .THRES(127),   .REGISTER_OUTPUT(1))
    u_reg    (.clk(clk), .rst(rst_r), .data_in(data_r), .result(res_reg));

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Decode binary16 to its real value and compare |x| against the threshold.
  function automatic logic ref_outlier(input logic [15:0] x, input int unsigned thr);
    int  e;
    int  m;
    real v;
    e = 32'(x[14:10]);
    m = 32'(x[9:0]);
    if (e == 31) return (m == 0);
    if (e == 0) begin
      v = m;
      e = 1;
    end else begin
      v = m + 1024;
    end
    // value = v * 2^(e-25)
    for (int k = e; k < 25; k++) v = v / 2.0;
    for (int k = 25; k < e; k++) v = v * 2.0;
    return v > real'(thr);
  endfunction

  task automatic apply_c(input logic [15:0] x);
    data_c = x;
    #1;
  endtask

  function automatic logic [15:0] near_127();
    logic [15:0] x;
    x = 16'h57E0 + 16'($urandom_range(0, 40));
    x[15] = 1'($urandom_range(0, 1));
    return x;
  endfunction

  initial begin
    logic [15:0] x;
    logic        exp_q;

    rst_n  = 1'b1;
    rst_r  = 1'b0;
    data_c = 16'h0000;
    data_r = 16'h5800;

    // Directed combinational cases
    apply_c(16'h57F0); check("t127_127.0",   res_127, 1'b0);
    apply_c(16'h5800); check("t127_128.0",   res_127, 1'b1);
    apply_c(16'h57F8); check("t127_127.5",   res_127, 1'b1);
    apply_c(16'hD800); check("t127_-128.0",  res_127, 1'b1);
    apply_c(16'hD7F0); check("t127_-127.0",  res_127, 1'b0);
    apply_c(16'h0000); check("t127_+0",      res_127, 1'b0);
    apply_c(16'h8000); check("t127_-0",      res_127, 1'b0);
    apply_c(16'h0001); check("t127_subnorm", res_127, 1'b0);
    apply_c(16'h7C00); check("t127_+inf",    res_127, 1'b1);
    apply_c(16'hFC00); check("t127_-inf",    res_127, 1'b1);
    apply_c(16'h7E00); check("t127_nan",     res_127, 1'b0);
    apply_c(16'hFE01); check("t127_-nan",    res_127, 1'b0);
    apply_c(16'h6800); check("t2049_2048",   res_2049, 1'b0);
    apply_c(16'h6801); check("t2049_2050",   res_2049, 1'b1);
    apply_c(16'h7BFF); check("t65535_max",   res_65535, 1'b0);
    apply_c(16'h7C00); check("t65535_inf",   res_65535, 1'b1);
    apply_c(16'h3C00); check("t1_1.0",       res_1, 1'b0);
    apply_c(16'h3C01); check("t1_1.0+ulp",   res_1, 1'b1);
    apply_c(16'h7BFF); check("t65504_max",   res_65504, 1'b0);

    // Exhaustive sweep for four thresholds
    for (int i = 0; i < 65536; i++) begin
      x = 16'(i);
      apply_c(x);
      check($sformatf("sweep_t1_%h",     x), res_1,     ref_outlier(x, 1));
      check($sformatf("sweep_t127_%h",   x), res_127,   ref_outlier(x, 127));
      check($sformatf("sweep_t1000_%h",  x), res_1000,  ref_outlier(x, 1000));
      check($sformatf("sweep_t65504_%h", x), res_65504, ref_outlier(x, 65504));
    end

    // Random patterns for the non-swept thresholds
    for (int i = 0; i < 2000; i++) begin
      x = (i % 2 == 0) ? 16'($urandom) : (16'h6800 + 16'($urandom_range(0, 3)));
      apply_c(x);
      check($sformatf("rand_t2049_%h",  x), res_2049,  ref_outlier(x, 2049));
      check($sformatf("rand_t65535_%h", x), res_65535, ref_outlier(x, 65535));
    end

    // Registered variant: held in reset with an outlier on the input
    @(negedge clk);
    check("reg_rst_init", res_reg, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reg_rst_hold", res_reg, 1'b0);
    end
    @(negedge clk) rst_r = 1'b1;
    #1 check("reg_rel_noedge", res_reg, 1'b0);
    @(posedge clk); #1;
    check("reg_first_cap", res_reg, 1'b1);
    data_r = 16'h3C00;
    @(posedge clk); #1;
    check("reg_one", res_reg, 1'b0);
    data_r = 16'h5800;
    @(posedge clk); #1;
    check("reg_128_again", res_reg, 1'b1);
    #2 rst_r = 1'b0;
    #1 check("reg_async_rst", res_reg, 1'b0);
    @(posedge clk); #1;
    check("reg_rst_discard", res_reg, 1'b0);

    // Random stream with one-cycle latency
    @(negedge clk) rst_r = 1'b1;
    x      = near_127();
    data_r = x;
    exp_q  = ref_outlier(x, 127);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      check($sformatf("reg_stream_%0d", i), res_reg, exp_q);
      x      = (i % 3 == 0) ? 16'($urandom) : near_127();
      data_r = x;
      exp_q  = ref_outlier(x, 127);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
